// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite collision snooper.
package sprite_pkg;

    localparam int unsigned SPR_INDEX_W    = 5;
    localparam int unsigned SPR_COUNT      = 32;
    localparam int unsigned COLL_RAM_AW    = 7;
    localparam int unsigned COLL_RAM_DEPTH = SPR_COUNT * 4;
    localparam int unsigned COLL_DW        = 8;
    localparam int unsigned SPR_LINE_MAX   = 352;
    localparam int unsigned PIX_X_W        = 9;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLR_COLL = 3'd1,
        ST_CLR_OCC  = 3'd2,
        ST_POP      = 3'd3,
        ST_OCC_CHK  = 3'd4,
        ST_RMW_A    = 3'd5,
        ST_RMW_B    = 3'd6,
        ST_OCC_WR   = 3'd7
    } coll_state_t;

    typedef struct packed {
        logic [PIX_X_W-1:0]     x;
        logic [SPR_INDEX_W-1:0] spr;
    } pix_evt_t;

    // Byte address holding the "victim collided with other" bit group.
    function automatic logic [COLL_RAM_AW-1:0] coll_addr(
        input logic [SPR_INDEX_W-1:0] victim,
        input logic [1:0]             other_hi
    );
        return {victim, other_hi};
    endfunction

endpackage

// File: rtl/sprite_event_fifo.sv
// Show-ahead synchronous FIFO for snooped pixel events, with flush.
module sprite_event_fifo
    import sprite_pkg::*;
#(
    parameter int unsigned DEPTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  pix_evt_t wdata,
    input  logic     pop,
    input  logic     flush,
    output pix_evt_t head_c,
    output logic     full_c,
    output logic     empty_c
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    pix_evt_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty_c && !flush;
    // A push into a full FIFO is still accepted when the head leaves the same cycle.
    assign do_push = push && !flush && (!full_c || do_pop);
    assign head_c  = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/sprite_collision.sv
// Snoops sprite pixel commits, tracks per-line X ownership and records pairwise collisions.
module sprite_collision
    import sprite_pkg::*;
#(
    parameter int unsigned OCC_DEPTH  = 512,
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   hsync,
    input  logic                   vsync,
    input  logic                   vblank,
    input  logic                   pix_valid,
    input  logic [PIX_X_W-1:0]     pix_x,
    input  logic [SPR_INDEX_W-1:0] pix_spr,
    output logic [COLL_RAM_AW-1:0] spritecollisionram_addr,
    input  logic [COLL_DW-1:0]     spritecollisionram_data_in,
    output logic [COLL_DW-1:0]     spritecollisionram_data_out,
    output logic                   spritecollisionram_wr,
    output logic                   coll_irq,
    output logic                   coll_overflow
);

    localparam int unsigned OCC_AW = (OCC_DEPTH > 1) ? $clog2(OCC_DEPTH) : 1;
    localparam int unsigned CNT_W  = (OCC_AW > COLL_RAM_AW) ? OCC_AW : COLL_RAM_AW;
    localparam int unsigned OCC_W  = SPR_INDEX_W + 1;

    coll_state_t            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]             sub_q, sub_d;
    logic [PIX_X_W-1:0]     cur_x_q, cur_x_d;
    logic [SPR_INDEX_W-1:0] cur_spr_q, cur_spr_d;
    logic [SPR_INDEX_W-1:0] other_q, other_d;
    logic                   hs_pend_q, hs_pend_d, vs_pend_q, vs_pend_d;
    logic                   hit_q, hit_d, ovf_q, ovf_d, irq_q, irq_d;
    logic [COLL_RAM_AW-1:0] addr_q, addr_d;
    logic [COLL_DW-1:0]     dout_q, dout_d;
    logic                   wr_q, wr_d;
    logic                   hs_d_q, vs_d_q, vb_d_q;
    logic                   hs_rise, vs_rise, vb_rise, hs_go, vs_go;

    pix_evt_t               push_evt, head;
    logic                   pop, flush, full, empty, x_ok;

    logic                   occ_we;
    logic [OCC_AW-1:0]      occ_waddr, occ_raddr;
    logic [OCC_W-1:0]       occ_wdata, occ_rdata;
    logic [OCC_W-1:0]       occ_mem [OCC_DEPTH];

    assign hs_rise = hsync & ~hs_d_q;
    assign vs_rise = vsync & ~vs_d_q;
    assign vb_rise = vblank & ~vb_d_q;
    assign hs_go   = hs_pend_q | hs_rise;
    assign vs_go   = vs_pend_q | vs_rise;
    assign push_evt = {pix_x, pix_spr};

    sprite_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (pix_valid),
        .wdata   (push_evt),
        .pop     (pop),
        .flush   (flush),
        .head_c  (head),
        .full_c  (full),
        .empty_c (empty)
    );

    // X values past the occupancy buffer are discarded.
    if (OCC_DEPTH >= (1 << PIX_X_W)) begin : g_x_full
        assign x_ok = 1'b1;
    end else begin : g_x_part
        assign x_ok = (32'(head.x) < OCC_DEPTH);
    end

    always_ff @(posedge clk) begin
        if (occ_we) occ_mem[occ_waddr] <= occ_wdata;
        occ_rdata <= occ_mem[occ_raddr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sub_q     <= '0;
            cur_x_q   <= '0;
            cur_spr_q <= '0;
            other_q   <= '0;
            hs_pend_q <= 1'b0;
            vs_pend_q <= 1'b0;
            hit_q     <= 1'b0;
            ovf_q     <= 1'b0;
            irq_q     <= 1'b0;
            addr_q    <= '0;
            dout_q    <= '0;
            wr_q      <= 1'b0;
            hs_d_q    <= 1'b0;
            vs_d_q    <= 1'b0;
            vb_d_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sub_q     <= sub_d;
            cur_x_q   <= cur_x_d;
            cur_spr_q <= cur_spr_d;
            other_q   <= other_d;
            hs_pend_q <= hs_pend_d;
            vs_pend_q <= vs_pend_d;
            hit_q     <= hit_d;
            ovf_q     <= ovf_d;
            irq_q     <= irq_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            wr_q      <= wr_d;
            hs_d_q    <= hsync;
            vs_d_q    <= vsync;
            vb_d_q    <= vblank;
        end
    end

    // RMW phases: issue address, wait for read data, then register the OR-ed write.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sub_d     = sub_q;
        cur_x_d   = cur_x_q;
        cur_spr_d = cur_spr_q;
        other_d   = other_q;
        hs_pend_d = hs_pend_q | hs_rise;
        vs_pend_d = vs_pend_q | vs_rise;
        hit_d     = hit_q;
        ovf_d     = ovf_q;
        irq_d     = vb_rise & hit_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        wr_d      = 1'b0;
        pop       = 1'b0;
        flush     = 1'b0;
        occ_we    = 1'b0;
        occ_waddr = OCC_AW'(cur_x_q);
        occ_wdata = {1'b1, cur_spr_q};
        occ_raddr = OCC_AW'(head.x);

        case (state_q)
            ST_IDLE: begin
                if (vs_go) begin
                    state_d   = ST_CLR_COLL;
                    cnt_d     = '0;
                    vs_pend_d = 1'b0;
                    ovf_d     = 1'b0;
                    hit_d     = 1'b0;
                end else if (hs_go) begin
                    state_d   = ST_CLR_OCC;
                    cnt_d     = '0;
                    hs_pend_d = 1'b0;
                    flush     = 1'b1;
                    if (!empty) ovf_d = 1'b1;
                end else if (!empty) begin
                    state_d = ST_POP;
                end
            end
            ST_CLR_COLL: begin
                wr_d   = 1'b1;
                addr_d = COLL_RAM_AW'(cnt_q);
                dout_d = '0;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(COLL_RAM_DEPTH - 1)) state_d = ST_IDLE;
            end
            ST_CLR_OCC: begin
                occ_we    = 1'b1;
                occ_waddr = OCC_AW'(cnt_q);
                occ_wdata = '0;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(OCC_DEPTH - 1)) state_d = ST_IDLE;
            end
            ST_POP: begin
                pop       = 1'b1;
                cur_x_d   = head.x;
                cur_spr_d = head.spr;
                state_d   = x_ok ? ST_OCC_CHK : ST_IDLE;
            end
            ST_OCC_CHK: begin
                if (occ_rdata[SPR_INDEX_W] && (occ_rdata[SPR_INDEX_W-1:0] != cur_spr_q)) begin
                    other_d = occ_rdata[SPR_INDEX_W-1:0];
                    sub_d   = '0;
                    state_d = ST_RMW_A;
                end else begin
                    state_d = ST_OCC_WR;
                end
            end
            ST_RMW_A: begin
                sub_d = sub_q + 2'd1;
                if (sub_q == 2'd0) begin
                    addr_d = coll_addr(cur_spr_q, other_q[4:3]);
                end else if (sub_q == 2'd2) begin
                    wr_d    = 1'b1;
                    dout_d  = spritecollisionram_data_in | (COLL_DW'(1) << other_q[2:0]);
                    sub_d   = '0;
                    state_d = ST_RMW_B;
                end
            end
            ST_RMW_B: begin
                sub_d = sub_q + 2'd1;
                if (sub_q == 2'd0) begin
                    addr_d = coll_addr(other_q, cur_spr_q[4:3]);
                end else if (sub_q == 2'd2) begin
                    wr_d    = 1'b1;
                    dout_d  = spritecollisionram_data_in | (COLL_DW'(1) << cur_spr_q[2:0]);
                    sub_d   = '0;
                    hit_d   = 1'b1;
                    state_d = ST_OCC_WR;
                end
            end
            ST_OCC_WR: begin
                occ_we = 1'b1;
                if (vs_go) begin
                    state_d = ST_IDLE;
                end else if (hs_go) begin
                    state_d   = ST_CLR_OCC;
                    cnt_d     = '0;
                    hs_pend_d = 1'b0;
                    flush     = 1'b1;
                    if (!empty) ovf_d = 1'b1;
                end else if (!empty) begin
                    state_d = ST_POP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Lost events: pushed into a full FIFO without a same-cycle pop, or during a flush.
        if (pix_valid && (flush || (full && !pop))) ovf_d = 1'b1;
    end

    assign spritecollisionram_addr     = addr_q;
    assign spritecollisionram_data_out = dout_q;
    assign spritecollisionram_wr       = wr_q;
    assign coll_irq                    = irq_q;
    assign coll_overflow               = ovf_q;

endmodule

// File: tb/tb_sprite_collision.sv
// Scoreboard bench: a reference occupancy/collision model predicts every collision RAM write.
module tb_sprite_collision;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } exp_wr_t;

    logic       clk = 1'b0;
    logic       reset, hsync, vsync, vblank, pix_valid;
    logic [8:0] pix_x;
    logic [4:0] pix_spr;
    logic [6:0] ram_addr;
    logic [7:0] ram_din, ram_dout;
    logic       ram_wr, coll_irq, coll_overflow;

    logic [7:0] ram [128];
    logic [7:0] ram_rd;

    exp_wr_t    exp_q [$];
    exp_wr_t    mon_e;
    logic [7:0] ref_coll [128];
    logic       ref_v [512];
    logic [4:0] ref_id [512];
    int         n_checks = 0;
    int         n_fail = 0;
    int         irq_cnt = 0;
    logic       found;

    always #5 clk = ~clk;

    sprite_collision #(.OCC_DEPTH(512), .FIFO_DEPTH(32)) dut (
        .clk                         (clk),
        .reset                       (reset),
        .hsync                       (hsync),
        .vsync                       (vsync),
        .vblank                      (vblank),
        .pix_valid                   (pix_valid),
        .pix_x                       (pix_x),
        .pix_spr                     (pix_spr),
        .spritecollisionram_addr     (ram_addr),
        .spritecollisionram_data_in  (ram_din),
        .spritecollisionram_data_out (ram_dout),
        .spritecollisionram_wr       (ram_wr),
        .coll_irq                    (coll_irq),
        .coll_overflow               (coll_overflow)
    );

    // External collision RAM: read data registered one edge after the bus address.
    always @(posedge clk) begin
        if (ram_wr === 1'b1) ram[ram_addr] <= ram_dout;
        ram_rd <= ram[ram_addr];
    end
    assign ram_din = ram_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && ram_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'(ram_addr), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(ram_addr), 32'(mon_e.addr));
                check("wr_data", 32'(ram_dout), 32'(mon_e.data));
            end
        end
        if (coll_irq === 1'b1) irq_cnt++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_pair(input logic [4:0] victim, input logic [4:0] other);
        logic [6:0] a;
        a = {victim, other[4:3]};
        ref_coll[a] = ref_coll[a] | (8'd1 << other[2:0]);
        exp_q.push_back('{addr: a, data: ref_coll[a]});
    endtask

    task automatic model_pix(input int x, input logic [4:0] spr);
        if (ref_v[x] && ref_id[x] != spr) begin
            exp_pair(spr, ref_id[x]);
            exp_pair(ref_id[x], spr);
        end
        ref_v[x]  = 1'b1;
        ref_id[x] = spr;
    endtask

    task automatic send(input int x, input logic [4:0] spr, input int settle);
        model_pix(x, spr);
        pix_valid = 1'b1;
        pix_x     = 9'(x);
        pix_spr   = spr;
        tick();
        pix_valid = 1'b0;
        tick(settle);
    endtask

    task automatic do_hsync(input int settle);
        for (int i = 0; i < 512; i++) ref_v[i] = 1'b0;
        hsync = 1'b1;
        tick(2);
        hsync = 1'b0;
        tick(settle);
    endtask

    task automatic do_vsync();
        for (int i = 0; i < 128; i++) begin
            ref_coll[i] = 8'd0;
            exp_q.push_back('{addr: 7'(i), data: 8'd0});
        end
        vsync = 1'b1;
        tick(2);
        vsync = 1'b0;
        tick(140);
    endtask

    task automatic drain(input string tag);
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic vblank_irq(input string tag, input int exp_pulses);
        irq_cnt = 0;
        vblank = 1'b1;
        tick(2);
        vblank = 1'b0;
        tick(4);
        check(tag, 32'(irq_cnt), 32'(exp_pulses));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wr"},   32'(ram_wr),        32'd0);
        check({tag, "_addr"}, 32'(ram_addr),      32'd0);
        check({tag, "_dout"}, 32'(ram_dout),      32'd0);
        check({tag, "_irq"},  32'(coll_irq),      32'd0);
        check({tag, "_ovf"},  32'(coll_overflow), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; hsync = 1'b0; vsync = 1'b0; vblank = 1'b0;
        pix_valid = 1'b0; pix_x = '0; pix_spr = '0;
        for (int i = 0; i < 512; i++) begin
            ref_v[i]  = 1'b0;
            ref_id[i] = '0;
        end
        for (int i = 0; i < 128; i++) ref_coll[i] = 8'd0;
        tick(3);
        check_idle_outputs("reset");
        reset = 1'b1;
        tick(2);

        // Frame clear, then a 3/9 overlap at x=100 and the frame interrupt.
        do_vsync();
        drain("clr_coll_done");
        check("ovf_after_clr", 32'(coll_overflow), 32'd0);
        do_hsync(530);
        send(100, 5'd3, 15);
        send(100, 5'd9, 20);
        drain("coll_3_9");
        check("ram_0d", 32'(ram[7'h0D]), 32'h02);
        check("ram_24", 32'(ram[7'h24]), 32'h08);
        vblank_irq("irq_hit", 1);

        // Sprite overlapping itself: no writes, no interrupt.
        do_vsync();
        drain("clr_coll_2");
        do_hsync(530);
        send(40, 5'd5, 15);
        send(40, 5'd5, 20);
        drain("same_id");
        vblank_irq("irq_none", 0);

        // Occupancy does not carry across a line.
        send(10, 5'd2, 15);
        do_hsync(530);
        send(10, 5'd7, 20);
        drain("new_line");

        // 40 back-to-back events during the occupancy clear: only the first 32 fit.
        do_hsync(3);
        for (int i = 0; i < 40; i++) begin
            if (i < 32) model_pix(200 + i, 5'd1);
            pix_valid = 1'b1;
            pix_x     = 9'(200 + i);
            pix_spr   = 5'd1;
            tick();
        end
        pix_valid = 1'b0;
        tick(700);
        drain("burst_no_coll");
        check("ovf_burst", 32'(coll_overflow), 32'd1);
        send(231, 5'd2, 20);
        send(232, 5'd2, 20);
        drain("burst_last_kept");
        do_vsync();
        drain("clr_coll_3");
        check("ovf_cleared", 32'(coll_overflow), 32'd0);

        // Reset arriving while the first RMW write is on the bus.
        do_hsync(530);
        send(50, 5'd4, 15);
        exp_pair(5'd6, 5'd4);
        pix_valid = 1'b1;
        pix_x     = 9'd50;
        pix_spr   = 5'd6;
        tick();
        pix_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (ram_wr === 1'b1) found = 1'b1;
        end
        check("rst_wr_seen", 32'(found), 32'd1);
        #1 reset = 1'b0;
        #1 check("rst_wr_drop", 32'(ram_wr), 32'd0);
        tick(2);
        check_idle_outputs("midreset");
        drain("rst_exp_consumed");
        reset = 1'b1;
        tick(2);
        do_vsync();
        drain("post_rst_clr");
        do_hsync(530);
        send(60, 5'd8, 15);
        send(60, 5'd11, 20);
        drain("post_rst_coll");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
